// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package sync_fifo_pkg;

    localparam bit MODE_STD  = 1'b0;
    localparam bit MODE_FWFT = 1'b1;

    localparam int AE_LEVEL_DEFAULT  = 4;
    localparam int AF_MARGIN_DEFAULT = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_dp_ram.sv
// Single-clock simple dual-port RAM; registered read address, one-cycle read latency.
module sync_dp_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr_r,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_r_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr_w] <= din;
        end
        addr_r_q <= addr_r;
    end

    assign dout = mem[addr_r_q];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable FWFT/standard read, occupancy count,
// programmable almost flags, synchronous flush and sticky error flags.
module sync_fifo_fwft
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH_WIDTH = 10,
    parameter bit FWFT             = MODE_FWFT,
    parameter int AF_LEVEL         = (1 << FIFO_DEPTH_WIDTH) - AF_MARGIN_DEFAULT,
    parameter int AE_LEVEL         = AE_LEVEL_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     data_write,
    input  logic                      read,
    output logic [DATA_WIDTH-1:0]     data_read,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [FIFO_DEPTH_WIDTH:0] data_count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW    = FIFO_DEPTH_WIDTH;
    localparam int DEPTH = 1 << FIFO_DEPTH_WIDTH;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW:0]           wr_ptr, rd_ptr, count_next;
    logic                  we, re, ram_we, ram_has;
    logic                  rd_adv, load_out, pend_move;
    logic                  pend_q, pend_next, out_valid_q, out_valid_next, empty_next;
    logic [AW-1:0]         addr_r;
    logic [DATA_WIDTH-1:0] out_q, ram_dout;

    // write/read are requests sampled at the edge; each is accepted only if
    // full/empty was low before that edge, otherwise it sets overflow/underflow.
    assign we      = write && !full;
    assign re      = read && !empty;
    assign ram_we  = we && !flush;
    assign ram_has = (wr_ptr != rd_ptr);

    sync_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .addr_w (wr_ptr[AW-1:0]),
        .din    (data_write),
        .addr_r (addr_r),
        .dout   (ram_dout)
    );

    // pend_q marks a RAM word in flight on ram_dout. In FWFT mode it acts as a
    // second output slot so the head refills without a bubble.
    always_comb begin
        pend_move      = 1'b0;
        rd_adv         = re;
        load_out       = pend_q;
        pend_next      = re;
        out_valid_next = 1'b0;
        addr_r         = rd_ptr[AW-1:0];
        if (FWFT == MODE_FWFT) begin
            pend_move      = pend_q && (!out_valid_q || re);
            rd_adv         = ram_has && (!pend_q || pend_move);
            load_out       = pend_move;
            pend_next      = rd_adv || (pend_q && !pend_move);
            out_valid_next = pend_move || (out_valid_q && !re);
            if (!rd_adv) begin
                addr_r = rd_ptr[AW-1:0] - 1'b1;
            end
        end

        count_next = data_count;
        if (flush) begin
            count_next = '0;
        end else if (we && !re) begin
            count_next = data_count + 1'b1;
        end else if (re && !we) begin
            count_next = data_count - 1'b1;
        end

        if (flush) begin
            pend_next      = 1'b0;
            out_valid_next = 1'b0;
        end
        empty_next = (FWFT == MODE_FWFT) ? !out_valid_next : (count_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            data_count   <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            pend_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
        end else begin
            data_count   <= count_next;
            full         <= (count_next == FULL_COUNT);
            almost_full  <= (int'(count_next) >= AF_LEVEL);
            almost_empty <= (int'(count_next) <= AE_LEVEL);
            empty        <= empty_next;
            pend_q       <= pend_next;
            out_valid_q  <= out_valid_next;
            // flush keeps data_read steady in both modes
            if (load_out && !(flush && FWFT == MODE_FWFT)) begin
                out_q <= ram_dout;
            end
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (we) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (write && full) begin
                    overflow <= 1'b1;
                end
                if (read && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    assign data_read = (FWFT == MODE_STD && pend_q) ? ram_dout : out_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench: one standard-mode and one FWFT-mode FIFO driven in lockstep.
module tb_sync_fifo_fwft;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          chk_data;
        logic          empty;
        logic          full;
        logic          af;
        logic          ae;
        logic          ovf;
        logic          unf;
        logic [CW-1:0] count;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, write, read;
    logic [DW-1:0] data_write;

    logic [DW-1:0] s_data, f_data;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] s_count, f_count;

    int vectors     = 0;
    int miscompares = 0;

    exp_t exp_std_q[$];
    exp_t exp_fw_q[$];

    // reference model: index 0 = standard mode, 1 = FWFT; words kept by sequence number
    logic [DW-1:0] mdat [2][256];
    int            mt   [2][256];
    int            head [2];
    int            tail [2];
    logic [DW-1:0] last [2];
    logic          ovf_m [2];
    logic          unf_m [2];
    logic          pe    [2];
    int            tnow = 0;

    always #5 clk = ~clk;

    sync_fifo_fwft #(
        .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW), .FWFT(1'b0), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .write(write), .data_write(data_write),
        .read(read), .data_read(s_data), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .data_count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_fwft #(
        .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW), .FWFT(1'b1), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .write(write), .data_write(data_write),
        .read(read), .data_read(f_data), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .data_count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic cmp(input string tag, input string fld, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s %s: got 0x%0h, required 0x%0h (t=%0t)", tag, fld, act, req, $time);
        end
    endtask

    task automatic check(input string tag, input exp_t e, input logic [DW-1:0] dr,
                         input logic emp, input logic ful, input logic af, input logic ae,
                         input logic ovf, input logic unf, input logic [CW-1:0] cnt);
        cmp(tag, "data_count", int'(cnt), int'(e.count));
        cmp(tag, "empty", int'(emp), int'(e.empty));
        cmp(tag, "full", int'(ful), int'(e.full));
        cmp(tag, "almost_full", int'(af), int'(e.af));
        cmp(tag, "almost_empty", int'(ae), int'(e.ae));
        cmp(tag, "overflow", int'(ovf), int'(e.ovf));
        cmp(tag, "underflow", int'(unf), int'(e.unf));
        if (e.chk_data) begin
            cmp(tag, "data_read", int'(dr), int'(e.data));
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            head[m]  = 0;
            tail[m]  = 0;
            last[m]  = '0;
            ovf_m[m] = 1'b0;
            unf_m[m] = 1'b0;
            pe[m]    = 1'b1;
        end
    endtask

    // Apply one clock edge to the model and queue what each DUT must show afterwards.
    // In FWFT mode a word becomes readable two edges after it was written.
    task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        exp_t e;
        int   c;
        logic acc_w, acc_r;
        tnow++;
        for (int m = 0; m < 2; m++) begin
            c = tail[m] - head[m];
            if (f) begin
                head[m]  = tail[m];
                ovf_m[m] = 1'b0;
                unf_m[m] = 1'b0;
            end else begin
                acc_w = w && (c != DEPTH);
                acc_r = r && !pe[m];
                if (w && c == DEPTH) ovf_m[m] = 1'b1;
                if (r && pe[m]) unf_m[m] = 1'b1;
                if (acc_r) begin
                    last[m] = mdat[m][head[m] % 256];
                    head[m]++;
                end
                if (acc_w) begin
                    mdat[m][tail[m] % 256] = d;
                    mt[m][tail[m] % 256]   = tnow;
                    tail[m]++;
                end
            end
            c = tail[m] - head[m];
            e.count = CW'(c);
            e.full  = (c == DEPTH);
            e.af    = (c >= AF);
            e.ae    = (c <= AE);
            e.ovf   = ovf_m[m];
            e.unf   = unf_m[m];
            if (m == 0) begin
                e.empty    = (c == 0);
                e.data     = last[m];
                e.chk_data = 1'b1;
            end else begin
                e.empty    = (c == 0) || (mt[m][head[m] % 256] > tnow - 2);
                e.data     = mdat[m][head[m] % 256];
                e.chk_data = !e.empty;
            end
            pe[m] = e.empty;
            if (m == 0) exp_std_q.push_back(e);
            else        exp_fw_q.push_back(e);
        end
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        write      = w;
        data_write = d;
        read       = r;
        flush      = f;
        @(posedge clk);
        if (rst_n) model_edge(w, d, r, f);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    endtask

    task automatic check_reset(input string when);
        exp_t e;
        e = '0;
        e.empty = 1'b1;
        e.ae = 1'b1;
        e.chk_data = 1'b1;
        check({"std_", when}, e, s_data, s_empty, s_full, s_af, s_ae, s_ovf, s_unf, s_count);
        check({"fwft_", when}, e, f_data, f_empty, f_full, f_af, f_ae, f_ovf, f_unf, f_count);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic reset_mid();
        write = 1'b0;
        read  = 1'b0;
        flush = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        exp_std_q.delete();
        exp_fw_q.delete();
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (exp_std_q.size() > 0) begin
                e = exp_std_q.pop_front();
                check("std", e, s_data, s_empty, s_full, s_af, s_ae, s_ovf, s_unf, s_count);
            end
            if (exp_fw_q.size() > 0) begin
                e = exp_fw_q.pop_front();
                check("fwft", e, f_data, f_empty, f_full, f_af, f_ae, f_ovf, f_unf, f_count);
            end
        end
    end

    initial begin
        int   n_w, wp, rp, cyc;
        logic w, r;
        rst_n      = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        flush      = 1'b0;
        data_write = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        check_reset("reset");
        rst_n = 1'b1;

        // fill to full, then one write too many
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        idle(2);

        // single word through an empty FIFO
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // simultaneous read and write at count 5
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // read while empty, then flush clears underflow
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1);

        // wrap-around at varying random rates
        n_w = 0;
        wp  = 50;
        rp  = 50;
        for (cyc = 0; cyc < 3000 && n_w < 3 * DEPTH + 7; cyc++) begin
            if (cyc % 16 == 0) begin
                wp = int'($urandom_range(20, 90));
                rp = int'($urandom_range(20, 90));
            end
            w = (int'($urandom_range(0, 99)) < wp) && (tail[0] - head[0] < DEPTH);
            r = (int'($urandom_range(0, 99)) < rp) && !pe[0] && !pe[1];
            step(w, 8'($urandom_range(0, 255)), r, 1'b0);
            if (w) n_w++;
        end
        cmp("wrap", "writes_within_budget", n_w, 3 * DEPTH + 7);
        for (cyc = 0; cyc < 200 && (tail[0] != head[0] || tail[1] != head[1]); cyc++) begin
            step(1'b0, 8'($urandom_range(0, 255)), !pe[0] && !pe[1], 1'b0);
        end
        cmp("wrap", "drained_within_budget", int'(tail[0] != head[0] || tail[1] != head[1]), 0);

        // asynchronous reset mid-burst at count 9, then fresh traffic
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        reset_mid();
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Single-clock parametrised FIFO, the successor to the team's dual-clock FIFO, for intra-domain buffering in the camera pipeline (pixel packing, line buffering ahead of the VGA/SDRAM writers). It adds the following over the previous generation:
- selectable first-word-fall-through (FWFT) or standard read mode;
- a full-range occupancy count;
- programmable almost-full and almost-empty flags;
- synchronous flush;
- sticky overflow and underflow error flags.

Parameters:
DATA_WIDTH, 8, word width in bits.
FIFO_DEPTH_WIDTH, 10, log2 of capacity; capacity DEPTH = 2**FIFO_DEPTH_WIDTH.
FWFT, 1, 1 = first-word-fall-through, 0 = standard mode (data one cycle after read).
AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL.

Ports:
clk  in  1  single clock, all logic on its rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
flush  in  1  synchronous clear of FIFO contents and state.
write  in  1  write request.
data_write  in  DATA_WIDTH  write data.
read  in  1  read request (FWFT: pop the current head).
data_read  out  DATA_WIDTH  read data.
full  out  1  count == DEPTH.
empty  out  1  no word available to read.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
data_count  out  FIFO_DEPTH_WIDTH+1  words held, 0..DEPTH inclusive.
overflow  out  1  sticky; a write was attempted while full.
underflow  out  1  sticky; a read was attempted while empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - pointers = 0, data_count = 0;
  - empty = 1, full = 0, almost_full = 0, almost_empty = 1;
  - overflow = 0, underflow = 0;
  - data_read = 0, FWFT prefetch stage invalid.
- Reset mid-operation discards all contents. RAM contents are not cleared.
- Accept rules:
  - we = write && !full.
  - re = read && !empty.
  - A rejected write is dropped and sets overflow. A rejected read sets underflow.
  - full is evaluated before the edge: a write while full is rejected even if a read is accepted in the same cycle.
- Simultaneous read and write:
  - Both accepted: count unchanged.
  - Write while empty plus read: write accepted, read rejected, underflow set.
- Pointers: binary, FIFO_DEPTH_WIDTH+1 bits. Wrap modulo 2*DEPTH. The RAM address is the low FIFO_DEPTH_WIDTH bits.
- data_count: registered, updated +1 / -1 / 0 per cycle. Full width, so count == DEPTH is representable. Flags are registered and consistent with data_count in the same cycle.
- Standard mode (FWFT=0):
  - empty deasserts the cycle after the first accepted write.
  - data_read is valid 1 clock after an accepted read and holds until the next accepted read.
- FWFT mode (FWFT=1):
  - RAM plus a one-word output register. data_count and full include the word in the output register.
  - Write into an empty FIFO: empty deasserts and data_read shows that word 2 clocks after the write edge.
  - An accepted read presents the next word in the following cycle, with no bubble when RAM holds data.
  - When the last word is read, empty asserts the next cycle.
- flush: takes priority over write and read in the same cycle. Next cycle state equals the reset state, except overflow and underflow clear and data_read holds its value. Takes effect in 1 cycle.
- Full/empty boundaries:
  - Exactly DEPTH accepted writes with no reads gives full = 1, data_count = DEPTH.
  - DEPTH reads from full gives empty = 1, count = 0.

Decomposition:
- Package sync_fifo_pkg holds:
  - clog2 helper function;
  - mode constants MODE_STD = 0 and MODE_FWFT = 1;
  - default threshold constants.
- One sub-module, sync_dp_ram: single-clock simple dual-port RAM.
  - Registered read address, 1-cycle read latency.
  - Write port (we, addr_w, din) and read port (addr_r, dout).
  - Inferable as block RAM.
- FWFT prefetch logic, flags and counters stay in the top module.

Test Plan:
1. DEPTH=16, FWFT=0. Write 0x01..0x10 (16 writes) -> full=1, data_count=16, almost_full=1 from count 12. A 17th write -> dropped, overflow=1, count stays 16.
2. FWFT=1, empty FIFO. Write 0xA5 at edge N -> empty=0 and data_read=0xA5 at N+2. Read -> empty=1 next cycle, data_count=0.
3. FWFT=0, count=5. Read and write (0x3C) in the same cycle for 10 cycles -> data_count stays 5, output sequence in original order, then 0x3C words.
4. Empty FIFO. Read -> underflow=1 sticky, empty stays 1. Then flush -> underflow=0, count=0.
5. Wrap-around: 3*DEPTH+7 interleaved writes and reads at random rates -> read data matches a scoreboard, no overflow or underflow, data_count always equals writes minus reads.
6. Assert rst_n=0 mid-burst at count=9 -> empty=1, data_count=0, flags cleared immediately (asynchronous). After release, the first write/read pair returns the new data.
